// File: rtl/loop_ctrl.sv
// -----------------------------------------------------------------------------
// loop_ctrl
//   Bracket/loop sequencer for the brainfuck core. It owns the control side of
//   the return-address stack (stack2): on '[' it either pushes the loop PC or
//   enters skip-forward mode, and on ']' it either jumps back to the loop body
//   or pops the finished loop. It also tracks live stack depth and skip-mode
//   nesting, and raises a sticky error on overflow/underflow.
//
// Ports
//   clk        in   clock, all state on posedge
//   resetq     in   asynchronous active-low reset
//   flush      in   synchronous restart (RUN, depth/nest cleared, err cleared)
//   op_valid   in   decoder presents an op
//   op_ready   out  op accepted when op_valid & op_ready
//   op_code    in   00 other, 01 '[', 10 ']', 11 other
//   pc         in   PC of the presented op
//   cell_zero  in   current data cell is zero (valid with op_valid)
//   jump       out  one-cycle pulse, fetch loads jump_pc
//   jump_pc    out  branch target, valid while jump=1
//   skip       out  skip-forward mode, core must not execute
//   err        out  sticky overflow/underflow/nest-overflow flag
//   depth      out  live stack entries
//   stk_we     out  stack2 write enable
//   stk_delta  out  stack2 delta (01 push, 11 pop, 00 hold)
//   stk_wd     out  stack2 write data (always pc)
//   stk_rd     in   stack2 top of stack
// -----------------------------------------------------------------------------
module loop_ctrl #(
  parameter int DEPTH  = 16,
  parameter int AW     = 16,
  parameter int NEST_W = 8,
  localparam int DW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetq,
  input  logic          flush,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [1:0]    op_code,
  input  logic [AW-1:0] pc,
  input  logic          cell_zero,
  output logic          jump,
  output logic [AW-1:0] jump_pc,
  output logic          skip,
  output logic          err,
  output logic [DW-1:0] depth,
  output logic          stk_we,
  output logic [1:0]    stk_delta,
  output logic [AW-1:0] stk_wd,
  input  logic [AW-1:0] stk_rd
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    SKIP = 2'd1,
    JUMP = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [1:0]    OP_OPEN  = 2'b01;
  localparam logic [1:0]    OP_CLOSE = 2'b10;
  localparam logic [1:0]    DELTA_PUSH = 2'b01;
  localparam logic [1:0]    DELTA_POP  = 2'b11;
  localparam logic [DW-1:0] DEPTH_MAX  = DW'(DEPTH);
  localparam logic [DW-1:0] DEPTH_ONE  = DW'(1);
  localparam logic [NEST_W-1:0] NEST_ONE = NEST_W'(1);

  state_t              state_q, state_d;
  logic [DW-1:0]       depth_q, depth_d;
  logic [NEST_W-1:0]   nest_q, nest_d;
  logic [AW-1:0]       jump_pc_q, jump_pc_d;
  logic                accept;

  // Ops are only taken while sequencing (RUN) or skipping (SKIP); a flush in
  // the same cycle blocks acceptance so the op cannot leak a stack strobe.
  assign op_ready = ((state_q == RUN) || (state_q == SKIP)) && !flush;
  assign accept   = op_valid && op_ready;

  assign jump    = (state_q == JUMP);
  assign skip    = (state_q == SKIP);
  assign err     = (state_q == ERR);
  assign depth   = depth_q;
  assign jump_pc = jump_pc_q;
  assign stk_wd  = pc;

  // State register: the stack itself is not cleared here, depth alone tells
  // which stack2 entries are live.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q   <= RUN;
      depth_q   <= '0;
      nest_q    <= '0;
      jump_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      depth_q   <= depth_d;
      nest_q    <= nest_d;
      jump_pc_q <= jump_pc_d;
    end
  end

  // Next-state and stack strobes. Strobes are combinational from the accepted
  // op so stack2 updates on the same edge that depth_q moves.
  always_comb begin
    state_d   = state_q;
    depth_d   = depth_q;
    nest_d    = nest_q;
    jump_pc_d = jump_pc_q;
    stk_we    = 1'b0;
    stk_delta = 2'b00;

    if (flush) begin
      state_d = RUN;
      depth_d = '0;
      nest_d  = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (accept) begin
            if (op_code == OP_OPEN) begin
              if (cell_zero) begin
                // Loop body is dead: skip forward to the matching ']'.
                state_d = SKIP;
                nest_d  = NEST_ONE;
              end else if (depth_q < DEPTH_MAX) begin
                stk_we    = 1'b1;
                stk_delta = DELTA_PUSH;
                depth_d   = depth_q + DEPTH_ONE;
              end else begin
                state_d = ERR;
              end
            end else if (op_code == OP_CLOSE) begin
              if (depth_q == '0) begin
                state_d = ERR;
              end else if (!cell_zero) begin
                // Return to the instruction after the matching '['.
                jump_pc_d = stk_rd + AW'(1);
                state_d   = JUMP;
              end else begin
                stk_delta = DELTA_POP;
                depth_d   = depth_q - DEPTH_ONE;
              end
            end
          end
        end

        SKIP: begin
          if (accept) begin
            if (op_code == OP_OPEN) begin
              if (&nest_q) begin
                state_d = ERR;
              end else begin
                nest_d = nest_q + NEST_ONE;
              end
            end else if (op_code == OP_CLOSE) begin
              nest_d = nest_q - NEST_ONE;
              if (nest_q == NEST_ONE) begin
                state_d = RUN;
              end
            end
          end
        end

        JUMP: begin
          state_d = RUN;
        end

        ERR: begin
          state_d = ERR;
        end

        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_loop_ctrl.sv
// -----------------------------------------------------------------------------
// tb_loop_ctrl
//   Self-checking bench for loop_ctrl. A behavioural model (PC queue as the
//   return stack, an integer nesting count, error and jump-pending flags) is
//   compared against the DUT on every falling edge. Directed sequences with
//   hand-computed literal expectations pin the model, then random traffic
//   exercises the rest.
// -----------------------------------------------------------------------------
module tb_loop_ctrl;

  localparam int DEPTH  = 4;
  localparam int AW     = 16;
  localparam int NEST_W = 3;
  localparam int DW     = $clog2(DEPTH + 1);
  localparam int NEST_MAX = (1 << NEST_W) - 1;

  logic          clk = 1'b0;
  logic          resetq;
  logic          flush;
  logic          opValid;
  logic          opReady;
  logic [1:0]    opCode;
  logic [AW-1:0] pc;
  logic          cellZero;
  logic          jump;
  logic [AW-1:0] jumpPc;
  logic          skip;
  logic          err;
  logic [DW-1:0] depth;
  logic          stkWe;
  logic [1:0]    stkDelta;
  logic [AW-1:0] stkWd;
  logic [AW-1:0] stkRd;

  int checkCount = 0;
  int passCount  = 0;

  // Behavioural model state
  logic [AW-1:0] mStack[$];
  int            mNest = 0;
  bit            mErr = 1'b0;
  bit            mJumpPending = 1'b0;
  logic [AW-1:0] mJumpTarget = '0;

  loop_ctrl #(.DEPTH(DEPTH), .AW(AW), .NEST_W(NEST_W)) dut (
    .clk(clk),
    .resetq(resetq),
    .flush(flush),
    .op_valid(opValid),
    .op_ready(opReady),
    .op_code(opCode),
    .pc(pc),
    .cell_zero(cellZero),
    .jump(jump),
    .jump_pc(jumpPc),
    .skip(skip),
    .err(err),
    .depth(depth),
    .stk_we(stkWe),
    .stk_delta(stkDelta),
    .stk_wd(stkWd),
    .stk_rd(stkRd)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time,
               actual, expected);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge; the stack top is
  // presented from the model's own PC queue.
  task automatic applyStimulus(input logic v, input logic [1:0] c,
                               input logic z, input logic [AW-1:0] p,
                               input logic f);
    @(posedge clk);
    #1;
    opValid  = v;
    opCode   = c;
    cellZero = z;
    pc       = p;
    flush    = f;
    stkRd    = (mStack.size() > 0) ? mStack[$] : 16'hBEEF;
  endtask

  // Compare the DUT against the model, then advance the model with the
  // inputs that the next rising edge will sample.
  always @(negedge clk) begin
    bit            expReady;
    bit            acc;
    logic          expWe;
    logic [1:0]    expDelta;

    if (!resetq) begin
      mStack.delete();
      mNest        = 0;
      mErr         = 1'b0;
      mJumpPending = 1'b0;
      mJumpTarget  = '0;
    end

    expReady = !mErr && !mJumpPending && !flush;
    acc      = opValid && expReady;
    expWe    = 1'b0;
    expDelta = 2'b00;
    if (acc && mNest == 0) begin
      if (opCode == 2'b01 && !cellZero && mStack.size() < DEPTH) begin
        expWe    = 1'b1;
        expDelta = 2'b01;
      end else if (opCode == 2'b10 && cellZero && mStack.size() > 0) begin
        expDelta = 2'b11;
      end
    end

    checkOutput("op_ready", 32'(opReady), 32'(expReady));
    checkOutput("jump", 32'(jump), 32'(mJumpPending));
    if (mJumpPending) checkOutput("jump_pc", 32'(jumpPc), 32'(mJumpTarget));
    checkOutput("skip", 32'(skip), 32'(!mErr && !mJumpPending && mNest > 0));
    checkOutput("err", 32'(err), 32'(mErr));
    checkOutput("depth", 32'(depth), 32'(mStack.size()));
    checkOutput("stk_we", 32'(stkWe), 32'(expWe));
    checkOutput("stk_delta", 32'(stkDelta), 32'(expDelta));
    if (expWe) checkOutput("stk_wd", 32'(stkWd), 32'(pc));

    if (resetq) begin
      if (flush) begin
        mStack.delete();
        mNest        = 0;
        mErr         = 1'b0;
        mJumpPending = 1'b0;
      end else if (mJumpPending) begin
        mJumpPending = 1'b0;
      end else if (acc) begin
        if (mNest == 0) begin
          if (opCode == 2'b01) begin
            if (cellZero) mNest = 1;
            else if (mStack.size() < DEPTH) mStack.push_back(pc);
            else mErr = 1'b1;
          end else if (opCode == 2'b10) begin
            if (mStack.size() == 0) begin
              mErr = 1'b1;
            end else if (!cellZero) begin
              mJumpTarget  = mStack[$] + 16'd1;
              mJumpPending = 1'b1;
            end else begin
              void'(mStack.pop_back());
            end
          end
        end else begin
          if (opCode == 2'b01) begin
            if (mNest == NEST_MAX) mErr = 1'b1;
            else mNest++;
          end else if (opCode == 2'b10) begin
            mNest--;
          end
        end
      end
    end
  end

  initial begin
    resetq   = 1'b0;
    flush    = 1'b0;
    opValid  = 1'b0;
    opCode   = 2'b00;
    pc       = '0;
    cellZero = 1'b0;
    stkRd    = '0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset depth", 32'(depth), 32'd0);
    checkOutput("reset jump", 32'(jump), 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);
    checkOutput("reset skip", 32'(skip), 32'd0);
    checkOutput("reset stk_delta", 32'(stkDelta), 32'd0);
    @(posedge clk);
    #1 resetq = 1'b1;

    // Push on '[' with non-zero cell
    applyStimulus(1'b1, 2'b01, 1'b0, 16'd5, 1'b0);
    @(negedge clk);
    checkOutput("push we", 32'(stkWe), 32'd1);
    checkOutput("push delta", 32'(stkDelta), 32'h1);
    checkOutput("push wd", 32'(stkWd), 32'd5);
    applyStimulus(1'b0, 2'b00, 1'b0, 16'd0, 1'b0);
    @(negedge clk);
    checkOutput("push depth", 32'(depth), 32'd1);

    // Jump back on ']' with non-zero cell, then pop on zero cell
    applyStimulus(1'b1, 2'b10, 1'b0, 16'd9, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 16'd0, 1'b0);
    @(negedge clk);
    checkOutput("jump pulse", 32'(jump), 32'd1);
    checkOutput("jump target", 32'(jumpPc), 32'd6);
    checkOutput("jump ready", 32'(opReady), 32'd0);
    applyStimulus(1'b0, 2'b00, 1'b0, 16'd0, 1'b0);
    @(negedge clk);
    checkOutput("jump end", 32'(jump), 32'd0);
    applyStimulus(1'b1, 2'b10, 1'b1, 16'd10, 1'b0);
    @(negedge clk);
    checkOutput("pop delta", 32'(stkDelta), 32'h3);
    checkOutput("pop we", 32'(stkWe), 32'd0);
    applyStimulus(1'b0, 2'b00, 1'b0, 16'd0, 1'b0);
    @(negedge clk);
    checkOutput("pop depth", 32'(depth), 32'd0);

    // Skip-forward with nesting
    applyStimulus(1'b1, 2'b01, 1'b1, 16'd3, 1'b0);
    @(negedge clk);
    checkOutput("skip entry strobe", 32'(stkDelta), 32'd0);
    applyStimulus(1'b1, 2'b01, 1'b0, 16'd4, 1'b0);
    @(negedge clk);
    checkOutput("skip active", 32'(skip), 32'd1);
    checkOutput("skip nested we", 32'(stkWe), 32'd0);
    applyStimulus(1'b1, 2'b00, 1'b0, 16'd5, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b0, 16'd6, 1'b0);
    @(negedge clk);
    checkOutput("skip close strobe", 32'(stkDelta), 32'd0);
    applyStimulus(1'b1, 2'b10, 1'b1, 16'd7, 1'b0);
    @(negedge clk);
    checkOutput("skip still", 32'(skip), 32'd1);
    applyStimulus(1'b0, 2'b00, 1'b0, 16'd0, 1'b0);
    @(negedge clk);
    checkOutput("skip exit", 32'(skip), 32'd0);
    checkOutput("skip depth", 32'(depth), 32'd0);

    // Stack overflow
    for (int i = 1; i <= DEPTH; i++) begin
      applyStimulus(1'b1, 2'b01, 1'b0, AW'(i), 1'b0);
    end
    applyStimulus(1'b0, 2'b00, 1'b0, 16'd0, 1'b0);
    @(negedge clk);
    checkOutput("full depth", 32'(depth), 32'd4);
    applyStimulus(1'b1, 2'b01, 1'b0, 16'd99, 1'b0);
    @(negedge clk);
    checkOutput("overflow we", 32'(stkWe), 32'd0);
    applyStimulus(1'b0, 2'b00, 1'b0, 16'd0, 1'b0);
    @(negedge clk);
    checkOutput("overflow err", 32'(err), 32'd1);
    checkOutput("overflow ready", 32'(opReady), 32'd0);

    // Flush clears the error; then underflow
    applyStimulus(1'b0, 2'b00, 1'b0, 16'd0, 1'b1);
    @(negedge clk);
    checkOutput("flush ready", 32'(opReady), 32'd0);
    applyStimulus(1'b0, 2'b00, 1'b0, 16'd0, 1'b0);
    @(negedge clk);
    checkOutput("flush err", 32'(err), 32'd0);
    checkOutput("flush ready after", 32'(opReady), 32'd1);
    checkOutput("flush depth", 32'(depth), 32'd0);
    applyStimulus(1'b1, 2'b10, 1'b0, 16'd8, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 16'd0, 1'b0);
    @(negedge clk);
    checkOutput("underflow err", 32'(err), 32'd1);
    applyStimulus(1'b0, 2'b00, 1'b0, 16'd0, 1'b1);

    // Skip-nesting overflow
    applyStimulus(1'b1, 2'b01, 1'b1, 16'd30, 1'b0);
    for (int i = 0; i < NEST_MAX - 1; i++) begin
      applyStimulus(1'b1, 2'b01, 1'b0, 16'd31, 1'b0);
    end
    applyStimulus(1'b1, 2'b01, 1'b0, 16'd32, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 16'd0, 1'b0);
    @(negedge clk);
    checkOutput("nest overflow err", 32'(err), 32'd1);
    checkOutput("nest overflow skip", 32'(skip), 32'd0);
    applyStimulus(1'b0, 2'b00, 1'b0, 16'd0, 1'b1);

    // Flush blocks a same-cycle op
    applyStimulus(1'b1, 2'b01, 1'b0, 16'd7, 1'b1);
    @(negedge clk);
    checkOutput("flush op ready", 32'(opReady), 32'd0);
    checkOutput("flush op we", 32'(stkWe), 32'd0);
    applyStimulus(1'b0, 2'b00, 1'b0, 16'd0, 1'b0);
    @(negedge clk);
    checkOutput("flush op depth", 32'(depth), 32'd0);

    // Asynchronous reset during JUMP
    applyStimulus(1'b1, 2'b01, 1'b0, 16'd20, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b0, 16'd21, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("pre-reset jump", 32'(jump), 32'd1);
    checkOutput("pre-reset target", 32'(jumpPc), 32'd21);
    #1;
    opValid = 1'b0;
    resetq  = 1'b0;
    #1;
    checkOutput("async jump", 32'(jump), 32'd0);
    checkOutput("async depth", 32'(depth), 32'd0);
    checkOutput("async jump_pc", 32'(jumpPc), 32'd0);
    @(posedge clk);
    #1 resetq = 1'b1;

    // Random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      applyStimulus(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                    2'($urandom_range(0, 3)),
                    ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
                    16'($urandom()),
                    ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
    end
    applyStimulus(1'b0, 2'b00, 1'b0, 16'd0, 1'b0);
    @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
